// File: rtl/controlador_alu_pkg.sv
// Shared definitions for the ALU sequencing controller: FSM state encodings
// and the fixed button map.
package controlador_alu_pkg;

  localparam int ESTADO_W = 2;

  typedef enum logic [ESTADO_W-1:0] {
    CARGA_A  = 2'd0,
    CARGA_B  = 2'd1,
    CARGA_OP = 2'd2,
    LISTO    = 2'd3
  } estado_t;

  localparam int BTN_A    = 0;
  localparam int BTN_B    = 1;
  localparam int BTN_OP   = 2;
  localparam int BTN_EXEC = 3;

endpackage

// File: rtl/controlador_alu_antirrebote.sv
// One push-button conditioner: 2-flop synchronizer, debounce counter and a
// registered one-cycle pulse on the debounced 0->1 transition.
module antirrebote #(
  parameter int CICLOS_DEBOUNCE = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic boton,
  output logic pulso
);

  localparam int CNT_W = $clog2(CICLOS_DEBOUNCE + 1);

  logic             sync_q1;
  logic             sync_q2;
  logic             estable;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             alcanza;

  assign cnt_inc = cnt + CNT_W'(1);
  assign alcanza = (cnt_inc == CNT_W'(CICLOS_DEBOUNCE));

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, which is what makes the sync chain two stages deep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      estable <= 1'b0;
      cnt     <= '0;
      pulso   <= 1'b0;
    end else begin
      sync_q1 <= boton;
      sync_q2 <= sync_q1;
      pulso   <= 1'b0;
      if (sync_q2 != estable) begin
        if (alcanza) begin
          estable <= sync_q2;
          cnt     <= '0;
          // Pulse on the same edge the level commits, only for a press.
          pulso   <= sync_q2;
        end else begin
          cnt <= cnt_inc;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/controlador_alu.sv
// Sequencing controller for the ALU datapath: conditions the buttons and steps
// the fixed load order A -> B -> opcode -> execute from the switch bus.
module controlador_alu
  import controlador_alu_pkg::*;
#(
  parameter int CANT_BUS_ENTRADA = 4,
  parameter int CANT_BUS_SALIDA  = 4,
  parameter int CANT_BITS_OPCODE = 4,
  parameter int CANT_BOTONES     = 4,
  parameter int CICLOS_DEBOUNCE  = 4
) (
  input  logic                        i_clock,
  input  logic                        i_reset,
  input  logic [CANT_BUS_ENTRADA-1:0] i_switches,
  input  logic [CANT_BOTONES-1:0]     i_botones,
  input  logic [CANT_BUS_SALIDA-1:0]  i_resultado,
  output logic [CANT_BUS_ENTRADA-1:0] o_reg_dato_A,
  output logic [CANT_BUS_ENTRADA-1:0] o_reg_dato_B,
  output logic [CANT_BITS_OPCODE-1:0] o_reg_opcode,
  output logic [CANT_BUS_SALIDA-1:0]  o_leds,
  output logic                        o_valido,
  output logic [ESTADO_W-1:0]         o_estado
);

  logic [CANT_BOTONES-1:0] pulsos;
  estado_t                 estado;
  estado_t                 estado_sig;
  logic                    cargar_a;
  logic                    cargar_b;
  logic                    cargar_op;
  logic                    ejecutar;

  for (genvar g = 0; g < CANT_BOTONES; g++) begin : g_boton
    antirrebote #(
      .CICLOS_DEBOUNCE(CICLOS_DEBOUNCE)
    ) u_antirrebote (
      .clk  (i_clock),
      .rst_n(i_reset),
      .boton(i_botones[g]),
      .pulso(pulsos[g])
    );
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) estado <= CARGA_A;
    else          estado <= estado_sig;
  end

  // Only the pulse expected by the current state acts; all others are dropped.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave one unassigned and infer a latch.
    estado_sig = estado;
    cargar_a   = 1'b0;
    cargar_b   = 1'b0;
    cargar_op  = 1'b0;
    ejecutar   = 1'b0;
    case (estado)
      CARGA_A:  if (pulsos[BTN_A])    begin cargar_a  = 1'b1; estado_sig = CARGA_B;  end
      CARGA_B:  if (pulsos[BTN_B])    begin cargar_b  = 1'b1; estado_sig = CARGA_OP; end
      CARGA_OP: if (pulsos[BTN_OP])   begin cargar_op = 1'b1; estado_sig = LISTO;    end
      LISTO:    if (pulsos[BTN_EXEC]) begin ejecutar  = 1'b1; estado_sig = CARGA_A;  end
      default:  estado_sig = CARGA_A;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      o_reg_dato_A <= '0;
      o_reg_dato_B <= '0;
      o_reg_opcode <= '0;
      o_leds       <= '0;
      o_valido     <= 1'b0;
    end else begin
      if (cargar_a)  o_reg_dato_A <= i_switches;
      if (cargar_b)  o_reg_dato_B <= i_switches;
      if (cargar_op) o_reg_opcode <= i_switches[CANT_BITS_OPCODE-1:0];
      if (ejecutar)  o_leds       <= i_resultado;
      // Strobe rides alongside the LED update, so it is high the cycle after.
      o_valido <= ejecutar;
    end
  end

  assign o_estado = estado;

endmodule

// File: tb/tb_controlador_alu.sv
// Directed bench for controlador_alu: an A+B ALU model feeds i_resultado and
// expected LED values are queued at execute and popped on each o_valido.
module tb_controlador_alu;

  localparam int C = 4;

  logic       clk;
  logic       rst_n;
  logic [3:0] switches;
  logic [3:0] botones;
  logic [3:0] resultado;
  logic [3:0] reg_a;
  logic [3:0] reg_b;
  logic [3:0] reg_op;
  logic [3:0] leds;
  logic       valido;
  logic [1:0] estado;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_valid  = 0;
  int unsigned cyc      = 0;
  logic [3:0]  sb[$];

  controlador_alu #(
    .CANT_BUS_ENTRADA(4),
    .CANT_BUS_SALIDA (4),
    .CANT_BITS_OPCODE(4),
    .CANT_BOTONES    (4),
    .CICLOS_DEBOUNCE (C)
  ) dut (
    .i_clock     (clk),
    .i_reset     (rst_n),
    .i_switches  (switches),
    .i_botones   (botones),
    .i_resultado (resultado),
    .o_reg_dato_A(reg_a),
    .o_reg_dato_B(reg_b),
    .o_reg_opcode(reg_op),
    .o_leds      (leds),
    .o_valido    (valido),
    .o_estado    (estado)
  );

  // Combinational ALU model: 4-bit add of the two operands.
  assign resultado = reg_a + reg_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Every strobe must match a queued execute; a second strobe cycle finds none.
  always @(negedge clk) begin
    if (valido) begin
      n_valid++;
      if (sb.size() == 0) check("valido_inesperado", 32'(valido), 32'd0);
      else                check("leds_scoreboard", 32'(leds), 32'(sb.pop_front()));
    end
  end

  task automatic ciclos(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulsar(input int idx, input logic [3:0] sw);
    switches     = sw;
    botones[idx] = 1'b1;
    ciclos(C + 4);
    botones[idx] = 1'b0;
    ciclos(C + 4);
  endtask

  int unsigned t;

  initial begin
    rst_n    = 1'b0;
    switches = 4'h0;
    botones  = 4'h0;
    ciclos(2);
    check("reset_a", 32'(reg_a), 32'd0);
    check("reset_leds", 32'(leds), 32'd0);
    check("reset_estado", 32'(estado), 32'd0);
    check("reset_valido", 32'(valido), 32'd0);
    rst_n = 1'b1;
    ciclos(C + 6);
    check("idle_estado", 32'(estado), 32'd0);
    check("idle_a", 32'(reg_a), 32'd0);

    // Full sequence: 3 + 5 with opcode 0.
    pulsar(0, 4'h3);
    check("seq_a", 32'(reg_a), 32'h3);
    check("seq_estado_b", 32'(estado), 32'd1);
    pulsar(1, 4'h5);
    check("seq_b", 32'(reg_b), 32'h5);
    check("seq_estado_op", 32'(estado), 32'd2);
    pulsar(2, 4'h0);
    check("seq_op", 32'(reg_op), 32'h0);
    check("seq_estado_listo", 32'(estado), 32'd3);
    sb.push_back(4'(4'h3 + 4'h5));
    pulsar(3, 4'h0);
    check("seq_leds", 32'(leds), 32'h8);
    check("seq_estado_a", 32'(estado), 32'd0);
    check("seq_n_valid", 32'(n_valid), 32'd1);

    // Out-of-order presses in CARGA_A are ignored.
    pulsar(1, 4'hF);
    pulsar(2, 4'hF);
    pulsar(3, 4'hF);
    check("ooo_a", 32'(reg_a), 32'h3);
    check("ooo_b", 32'(reg_b), 32'h5);
    check("ooo_op", 32'(reg_op), 32'h0);
    check("ooo_leds", 32'(leds), 32'h8);
    check("ooo_estado", 32'(estado), 32'd0);
    check("ooo_n_valid", 32'(n_valid), 32'd1);

    // Bounce: toggle every 2 cycles for 20 cycles, then hold.
    switches = 4'h7;
    for (int i = 0; i < 5; i++) begin
      botones[0] = 1'b1;
      ciclos(2);
      botones[0] = 1'b0;
      ciclos(2);
    end
    botones[0] = 1'b1;
    t = cyc + 1;
    ciclos(C + 2);
    check("bounce_cyc", 32'(cyc), 32'(t + C + 1));
    check("bounce_a_before", 32'(reg_a), 32'h3);
    check("bounce_estado_before", 32'(estado), 32'd0);
    ciclos(1);
    check("bounce_a_at_edge", 32'(reg_a), 32'h7);
    check("bounce_estado_after", 32'(estado), 32'd1);
    ciclos(4);
    botones[0] = 1'b0;
    ciclos(C + 4);
    check("bounce_estado_hold", 32'(estado), 32'd1);

    // Simultaneous btn1+btn2 in CARGA_B: only B loads.
    switches = 4'hA;
    botones  = 4'b0110;
    ciclos(C + 4);
    botones  = 4'b0000;
    ciclos(C + 4);
    check("simul_b", 32'(reg_b), 32'hA);
    check("simul_estado", 32'(estado), 32'd2);
    check("simul_op", 32'(reg_op), 32'h0);

    // Finish with an overflowing add: 7 + A truncates to 1.
    pulsar(2, 4'h9);
    check("op9", 32'(reg_op), 32'h9);
    check("op9_estado", 32'(estado), 32'd3);
    sb.push_back(4'(4'h7 + 4'hA));
    pulsar(3, 4'h0);
    check("ovf_leds", 32'(leds), 32'h1);
    check("ovf_n_valid", 32'(n_valid), 32'd2);

    // Reset two cycles before the execute pulse would appear.
    pulsar(0, 4'h2);
    pulsar(1, 4'h4);
    pulsar(2, 4'h6);
    check("pre_rst_estado", 32'(estado), 32'd3);
    botones[3] = 1'b1;
    t = cyc + 1;
    ciclos(C);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_a", 32'(reg_a), 32'd0);
    check("async_rst_b", 32'(reg_b), 32'd0);
    check("async_rst_op", 32'(reg_op), 32'd0);
    check("async_rst_leds", 32'(leds), 32'd0);
    check("async_rst_estado", 32'(estado), 32'd0);
    ciclos(1);
    rst_n = 1'b1;
    ciclos(C + 6);
    check("held_estado", 32'(estado), 32'd0);
    check("held_a", 32'(reg_a), 32'd0);
    check("held_leds", 32'(leds), 32'd0);
    botones[3] = 1'b0;
    ciclos(C + 4);
    check("final_n_valid", 32'(n_valid), 32'd2);
    check("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/controlador_alu.md
# controlador_alu

Sequencing controller for the ALU datapath on the board: conditions the raw push-buttons (2-flop synchronizer, per-button debounce, rising-edge pulse) and steps a fixed load sequence A → B → opcode → execute from the switch bus. It drives the ALU operand and opcode inputs, captures the ALU's combinational result into a registered LED output, and strobes a valid flag. It replaces the free-form configurator in the top level: the operator can only load in order, and the LEDs change only on an explicit execute.

## Interface
- CANT_BUS_ENTRADA, 4, switch/operand width
- CANT_BUS_SALIDA, 4, ALU result / LED width
- CANT_BITS_OPCODE, 4, opcode width; opcode taken from i_switches[CANT_BITS_OPCODE-1:0]
- CANT_BOTONES, 4, number of buttons (fixed at 4 by the button map)
- CICLOS_DEBOUNCE, 4, consecutive stable cycles required (≥1; board build overrides to ~1_000_000)

Ports:
- i_clock  in  1  system clock
- i_reset  in  1  asynchronous, active-low reset
- i_switches  in  CANT_BUS_ENTRADA  data/opcode source
- i_botones  in  CANT_BOTONES  raw buttons: [0] load A, [1] load B, [2] load opcode, [3] execute
- i_resultado  in  CANT_BUS_SALIDA  ALU result (combinational from o_reg_* outputs)
- o_reg_dato_A  out  CANT_BUS_ENTRADA  operand 1 to ALU
- o_reg_dato_B  out  CANT_BUS_ENTRADA  operand 2 to ALU
- o_reg_opcode  out  CANT_BITS_OPCODE  opcode to ALU
- o_leds  out  CANT_BUS_SALIDA  registered result
- o_valido  out  1  one-cycle strobe, high the cycle after o_leds updates
- o_estado  out  2  current FSM state encoding

## Operation
- Reset (i_reset=0, async): all outputs 0. FSM in CARGA_A. Synchronizers, debounce counters, stable levels and pulses all 0.
- Per button: 2-flop sync → debounce → pulse.
  - Debounce: if the synced value ≠ stable, the counter increments. When the counter would reach CICLOS_DEBOUNCE, stable ← synced and the counter clears. If the synced value equals stable, the counter clears.
  - Pulse: registered, high exactly one cycle when stable goes 0→1. Release (1→0) produces no pulse.
- FSM states and encoding:
  - CARGA_A=0: pulse[0] → o_reg_dato_A ← i_switches; go to CARGA_B.
  - CARGA_B=1: pulse[1] → o_reg_dato_B ← i_switches; go to CARGA_OP.
  - CARGA_OP=2: pulse[2] → o_reg_opcode ← i_switches[CANT_BITS_OPCODE-1:0]; go to LISTO.
  - LISTO=3: pulse[3] → o_leds ← i_resultado, o_valido ← 1 next cycle; go to CARGA_A.
- In each state only the expected button's pulse acts. All other pulses are dropped, not queued. Simultaneous pulses therefore act only on the expected one.
- Operand/opcode registers hold their values until reloaded. o_leds holds until the next execute.
- Width rules: no arithmetic on data. Switches are copied bit-exact; the opcode uses the low bits.
- Reset mid-debounce or mid-sequence: immediate return to reset values. A button still held through reset release generates a pulse after the full debounce time, because stable restarts at 0.

## Timing
- Button sampled high first at edge t, and held: pulse high between edges t+CICLOS_DEBOUNCE+1 and t+CICLOS_DEBOUNCE+2. The register load / o_leds update occurs at edge t+CICLOS_DEBOUNCE+2.
- o_valido is high for the single cycle following the o_leds update edge.
- A glitch shorter than CICLOS_DEBOUNCE synced cycles produces no pulse and leaves the counter at 0 afterwards.
- The ALU path is combinational. i_resultado is valid one cycle after the last o_reg_* load, well before any execute.

## Structure
- Package controlador_alu_pkg:
  - state encodings CARGA_A/CARGA_B/CARGA_OP/LISTO
  - button indices BTN_A=0, BTN_B=1, BTN_OP=2, BTN_EXEC=3
  - state width 2
- Sub-module antirrebote: one button covering sync, debounce counter and pulse, with parameter CICLOS_DEBOUNCE. Instantiated CANT_BOTONES times via generate.
- Counter width is $clog2(CICLOS_DEBOUNCE+1).

## Test plan
- Reset: drive i_reset=0 mid-stream → all outputs 0, o_estado=0 asynchronously. Release → no pulse without button activity.
- Full sequence (N=4): switches 4'h3 + btn0, 4'h5 + btn1, 4'h0 + btn2, ALU model returns A+B, then btn3 → o_reg_dato_A=3, o_reg_dato_B=5, o_reg_opcode=0, o_leds=8, one o_valido pulse, o_estado back to 0.
- Bounce: btn0 toggles every 2 cycles for 20 cycles then holds high → exactly one load of A, at edge (last rising sample)+CICLOS_DEBOUNCE+2.
- Out-of-order: in CARGA_A press btn1, btn2, btn3 → no register change, o_estado stays 0, o_valido never high.
- Simultaneous: in CARGA_B press btn1 and btn2 together with switches=4'hA → B=4'hA, state CARGA_OP, opcode unchanged.
- Reset mid-debounce: btn3 held in LISTO, reset asserted 2 cycles before the pulse → no o_leds update. Button still held after release → pulse arrives, but the FSM is in CARGA_A, so it is ignored.
